green_timer: RTL and testbench
==============================

GREEN_TIMER -- requirements
Module: green_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clk cycles per second; legal range 2 or more.
REQ-002 Parameter SHORT_SEC, default 10: seconds loaded for a short request.
REQ-003 Parameter LONG_SEC, default 60: seconds loaded for a long request; legal range 1 to 63; must exceed SHORT_SEC.
REQ-004 Parameter YELLOW_SEC, default 3: closing-warning window in seconds; must be less than SHORT_SEC.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 short_counter  in  1  short-interval request from the light controller.
REQ-008 long_counter  in  1  long-interval request from the light controller.
REQ-009 current_state  in  4  one-hot controller state (0001, 0010, 0100 or 1000).
REQ-010 counter_done  out  1  registered pulse, one cycle wide: interval expired.
REQ-011 remaining_sec  out  6  whole seconds left in the active interval; 0 when not running.
REQ-012 yellow  out  1  high in RUN while remaining_sec <= YELLOW_SEC.
REQ-013 busy  out  1  high in RUN.

Function
REQ-014 FSM states: IDLE, RUN, DONE, WAIT; all state, count and output registers update on the rising edge of clk only.
REQ-015 IDLE, request sampled: on an edge where long_counter=1, load remaining_sec=LONG_SEC and prescaler=0, then go to RUN.
REQ-016 IDLE, short only: on an edge where long_counter=0 and short_counter=1, load SHORT_SEC the same way.
REQ-017 Both requests high: long wins, load LONG_SEC.
REQ-018 No request: with neither request high, stay in IDLE with counter_done=0; the controller advances on its own.
REQ-019 Prescaler: each RUN edge increments the prescaler; at CLK_HZ-1 it wraps to 0 and remaining_sec decrements by 1.
REQ-020 Expiry: the wrap that takes remaining_sec from 1 to 0 moves the FSM to DONE, with counter_done=1 from exactly N*CLK_HZ edges after the load edge (N = loaded seconds).
REQ-021 DONE lasts exactly one cycle, then goes to WAIT, with counter_done=0.
REQ-022 WAIT holds until current_state differs from the value latched at load, then goes to IDLE; a request is never reloaded within the same controller state.
REQ-023 Abort on state change: if current_state changes during RUN, abandon the interval, go to IDLE, and do not pulse counter_done.
REQ-024 Abort on request drop: if both requests drop to 0 during RUN, go to IDLE with no pulse.
REQ-025 Request upgrade during RUN: short-to-long or long-to-short changes are ignored; the loaded length is kept.
REQ-026 Illegal current_state: a value that is not one-hot forces IDLE and suppresses counter_done.
REQ-027 Idle outputs: remaining_sec and the prescaler are held at 0 in IDLE, DONE and WAIT.

Reset
REQ-028 Reset state: asserting rst_n forces IDLE, prescaler=0, remaining_sec=0, counter_done=0, yellow=0 and busy=0 immediately, including mid-interval.
REQ-029 Reset release: after rst_n deasserts, the first active edge samples requests as in IDLE.

Configuration
REQ-030 Macro GREEN_TIMER_OVERRIDE_EN, when defined, adds input i_force_done (1 bit).
REQ-031 Override behaviour: with the macro defined, i_force_done=1 in RUN moves the FSM to DONE on the next edge, so counter_done pulses one cycle and the count clears.
REQ-032 Override ignored outside RUN: i_force_done has no effect in IDLE, DONE or WAIT.
REQ-033 Macro undefined: the port does not exist and the behaviour is exactly REQ-014 to REQ-029.

Structure
REQ-034 Shared package traffic_pkg holds:
- the one-hot controller state typedef (light_1 to light_4);
- the timer FSM state typedef;
- default SHORT_SEC, LONG_SEC and YELLOW_SEC constants.
REQ-035 Sub-module sec_prescaler (clear and enable in, one-cycle tick out, $clog2(CLK_HZ)-bit counter) generates the one-second tick.

Verification (CLK_HZ=4, SHORT=10, LONG=60, YELLOW=3)
REQ-036 Short interval: short_counter=1 in state 0001 -> counter_done pulses one cycle exactly 40 edges after the load edge; yellow high for the final 12 cycles of RUN.
REQ-037 Long interval with both requests: long_counter=short_counter=1 -> remaining_sec loads 60 and counter_done is seen 240 edges after load.
REQ-038 Abort on state change: current_state changes 0001->0010 at edge 15 of a short interval -> no counter_done, and the FSM is back in IDLE with a fresh load on the following request.
REQ-039 Reset mid-interval: rst_n low at edge 20 -> all outputs 0 immediately; after release, a short request times a full 40 edges.
REQ-040 No request: both requests 0 -> busy=0 and counter_done never asserts.
REQ-041 With GREEN_TIMER_OVERRIDE_EN, forced done: i_force_done=1 at RUN edge 8 -> counter_done on the next edge and remaining_sec=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic light controller and its timers.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package traffic_pkg;

    // One-hot light controller state.
    typedef enum logic [3:0] {
        LIGHT_1 = 4'b0001,
        LIGHT_2 = 4'b0010,
        LIGHT_3 = 4'b0100,
        LIGHT_4 = 4'b1000
    } light_t;

    // Green timer FSM state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_WAIT = 2'd3
    } timer_state_t;

    localparam int DEF_SHORT_SEC  = 10;
    localparam int DEF_LONG_SEC   = 60;
    localparam int DEF_YELLOW_SEC = 3;

    // True when exactly one bit of the controller state is set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk by CLK_HZ into a one-cycle tick on the last cycle of each second.
// Latency: tick is combinational from the counter; counter updates each enabled edge.
// Backpressure: none; clr wins over en and restarts the second from zero.
module sec_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Tick does not look at clr so the FSM can use it to decide its own next state.
    assign tick = en && (cnt_q == CNT_MAX);

    // Next count: clear, wrap at the end of a second, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/green_timer.sv
// Green-phase interval timer: loads short/long seconds on request, counts down, pulses done.
// Latency: counter_done rises exactly N*CLK_HZ edges after the load edge; other outputs follow state.
// Backpressure: none; aborts on controller state change or request drop. GREEN_TIMER_OVERRIDE_EN adds i_force_done.
module green_timer
    import traffic_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SHORT_SEC  = DEF_SHORT_SEC,
    parameter int LONG_SEC   = DEF_LONG_SEC,
    parameter int YELLOW_SEC = DEF_YELLOW_SEC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       short_counter,
    input  logic       long_counter,
    input  logic [3:0] current_state,
`ifdef GREEN_TIMER_OVERRIDE_EN
    input  logic       i_force_done,
`endif
    output logic       counter_done,
    output logic [5:0] remaining_sec,
    output logic       yellow,
    output logic       busy
);

    timer_state_t state_q, state_d;
    logic [5:0]   rem_q, rem_d;
    light_t       latch_q, latch_d;
    logic         done_q, done_d;

    logic tick;
    logic force_done;
    logic legal;
    logic req_any;
    logic presc_clr;
    logic presc_en;

`ifdef GREEN_TIMER_OVERRIDE_EN
    assign force_done = i_force_done;
`else
    assign force_done = 1'b0;
`endif

    assign legal   = is_one_hot(current_state);
    assign req_any = short_counter | long_counter;

    // The prescaler restarts on the load edge and stays cleared whenever we are not counting.
    assign presc_en  = (state_q == ST_RUN);
    assign presc_clr = (state_q != ST_RUN) || (state_d != ST_RUN);

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    // Next-state, countdown and load logic; aborts take priority over expiry so they never pulse done.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        latch_d = latch_q;
        unique case (state_q)
            ST_IDLE: begin
                rem_d = 6'd0;
                if (legal && req_any) begin
                    state_d = ST_RUN;
                    rem_d   = long_counter ? 6'(LONG_SEC) : 6'(SHORT_SEC);
                    latch_d = light_t'(current_state);
                end
            end
            ST_RUN: begin
                if (!legal || (current_state != latch_q) || !req_any) begin
                    state_d = ST_IDLE;
                    rem_d   = 6'd0;
                end else if (force_done) begin
                    state_d = ST_DONE;
                    rem_d   = 6'd0;
                end else if (tick) begin
                    if (rem_q <= 6'd1) begin
                        state_d = ST_DONE;
                        rem_d   = 6'd0;
                    end else begin
                        rem_d = rem_q - 6'd1;
                    end
                end
            end
            ST_DONE: begin
                rem_d   = 6'd0;
                state_d = legal ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                rem_d = 6'd0;
                if (!legal || (current_state != latch_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = 6'd0;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // State, count, latched controller state and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 6'd0;
            latch_q <= LIGHT_1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            latch_q <= latch_d;
            done_q  <= done_d;
        end
    end

    assign counter_done  = done_q;
    assign remaining_sec = rem_q;
    assign busy          = (state_q == ST_RUN);
    assign yellow        = busy && (rem_q <= 6'(YELLOW_SEC));

endmodule

// File: tb/tb_green_timer.sv
// Directed bench for green_timer at CLK_HZ=4, SHORT=10, LONG=60, YELLOW=3.
// Latency: steps one clk edge at a time; outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_green_timer;

    logic       clk;
    logic       rst_n;
    logic       short_counter;
    logic       long_counter;
    logic [3:0] current_state;
`ifdef GREEN_TIMER_OVERRIDE_EN
    logic       i_force_done;
`endif
    logic       counter_done;
    logic [5:0] remaining_sec;
    logic       yellow;
    logic       busy;

    int checks;
    int errors;

    green_timer #(
        .CLK_HZ    (4),
        .SHORT_SEC (10),
        .LONG_SEC  (60),
        .YELLOW_SEC(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .short_counter (short_counter),
        .long_counter  (long_counter),
        .current_state (current_state),
`ifdef GREEN_TIMER_OVERRIDE_EN
        .i_force_done  (i_force_done),
`endif
        .counter_done  (counter_done),
        .remaining_sec (remaining_sec),
        .yellow        (yellow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rem"}, 32'(remaining_sec), 32'd0);
        chk({tag, "_done"}, 32'(counter_done), 32'd0);
        chk({tag, "_yel"}, 32'(yellow), 32'd0);
    endtask

    // Request must already be driven with the FSM in IDLE. The next edge is the load edge;
    // done is expected exactly 4*n edges later, yellow on the last 12 RUN cycles.
    // With upgrade set, the request flips short->long partway through and must be ignored.
    task automatic time_interval(input string tag, input int n, input bit upgrade);
        int ycnt;
        ycnt = 0;
        step();
        chk({tag, "_load_rem"}, 32'(remaining_sec), 32'(n));
        chk({tag, "_load_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 4 * n; k++) begin
            if (upgrade && k == 5) begin
                long_counter  = 1'b1;
                short_counter = 1'b0;
            end
            step();
            if (k < 4 * n) begin
                chk({tag, "_done_early"}, 32'(counter_done), 32'd0);
                chk({tag, "_rem"}, 32'(remaining_sec), 32'(n - k / 4));
                chk({tag, "_yel"}, 32'(yellow), 32'(k >= 4 * n - 12));
                if (yellow) ycnt++;
            end else begin
                chk({tag, "_done"}, 32'(counter_done), 32'd1);
                chk({tag, "_done_rem"}, 32'(remaining_sec), 32'd0);
                chk({tag, "_done_busy"}, 32'(busy), 32'd0);
            end
        end
        chk({tag, "_yel_cycles"}, 32'(ycnt), 32'd12);
        step();
        chk({tag, "_done_width"}, 32'(counter_done), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        short_counter = 1'b0;
        long_counter  = 1'b0;
        current_state = 4'b0001;
`ifdef GREEN_TIMER_OVERRIDE_EN
        i_force_done  = 1'b0;
`endif

        // Reset state.
        #2 rst_n = 1'b0;
        #1 chk_idle("reset");
        step();
        step();
        rst_n = 1'b1;

        // No request: nothing runs, no pulse.
        for (int i = 0; i < 12; i++) begin
            step();
            chk("noreq_busy", 32'(busy), 32'd0);
            chk("noreq_done", 32'(counter_done), 32'd0);
        end

        // Short interval, then no reload while the controller stays in the same state.
        short_counter = 1'b1;
        time_interval("short", 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_noreload", 32'(busy), 32'd0);
        end

        // Leave WAIT, then both requests: long wins.
        short_counter = 1'b0;
        current_state = 4'b0010;
        step();
        chk_idle("to_idle");
        short_counter = 1'b1;
        long_counter  = 1'b1;
        time_interval("long", 60, 1'b0);

        // Abort on controller state change at edge 15, fresh load on the next edge.
        short_counter = 1'b0;
        long_counter  = 1'b0;
        current_state = 4'b0100;
        step();
        short_counter = 1'b1;
        step();
        chk("abort_load_rem", 32'(remaining_sec), 32'd10);
        for (int i = 1; i <= 14; i++) step();
        current_state = 4'b1000;
        step();
        chk_idle("abort_state");
        step();
        chk("reload_busy", 32'(busy), 32'd1);
        chk("reload_rem", 32'(remaining_sec), 32'd10);

        // Abort on request drop, then no pulse ever appears.
        for (int i = 0; i < 4; i++) step();
        short_counter = 1'b0;
        step();
        chk_idle("abort_drop");
        for (int i = 0; i < 45; i++) begin
            step();
            chk("abort_no_done", 32'(counter_done), 32'd0);
        end

        // Reset mid-interval at edge 20, then a full short interval with an ignored upgrade.
        current_state = 4'b0001;
        short_counter = 1'b1;
        step();
        for (int i = 1; i <= 19; i++) step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_idle("mid_reset");
        step();
        step();
        rst_n = 1'b1;
        time_interval("post_reset", 10, 1'b1);

        // Illegal controller state: forces IDLE, blocks loading, aborts a run without a pulse.
        current_state = 4'b0011;
        step();
        chk("illegal_wait_exit", 32'(busy), 32'd0);
        step();
        chk("illegal_noload", 32'(busy), 32'd0);
        current_state = 4'b0100;
        step();
        chk("legal_load_busy", 32'(busy), 32'd1);
        chk("legal_load_rem", 32'(remaining_sec), 32'd60);
        for (int i = 0; i < 3; i++) step();
        current_state = 4'b0110;
        step();
        chk_idle("illegal_abort");
        step();
        chk("illegal_no_done", 32'(counter_done), 32'd0);

`ifdef GREEN_TIMER_OVERRIDE_EN
        // Forced done at RUN edge 8.
        current_state = 4'b0001;
        step();
        chk("force_load_rem", 32'(remaining_sec), 32'd60);
        for (int i = 1; i <= 7; i++) step();
        i_force_done = 1'b1;
        step();
        chk("force_done", 32'(counter_done), 32'd1);
        chk("force_rem", 32'(remaining_sec), 32'd0);
        i_force_done = 1'b0;
        step();
        chk("force_done_width", 32'(counter_done), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
